// File: rtl/aes_vp_pkg.sv
// Shared definitions for the AES verification-platform blocks.
// Holds the block width and the serializer state encoding.
package aes_vp_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/aes_block_serializer_piso.sv
// Parallel-load, left-shift register; exposes only the head slice that is on the wire.
// Load wins over shift so a back-to-back reload never sees a stale shift.
module piso_shift #(
  parameter int DATA_W  = 128,
  parameter int SHIFT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic [SHIFT_W-1:0] o_head
);

  logic [DATA_W-1:0] r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
    end else if (i_shift) begin
      r_shift <= {r_shift[DATA_W-SHIFT_W-1:0], {SHIFT_W{1'b0}}};
    end
  end

  assign o_head = r_shift[DATA_W-1 -: SHIFT_W];

endmodule

// File: rtl/aes_block_serializer.sv
// Pops 128-bit plaintext blocks from the generator FIFO and streams them MSB-first
// as OUT_W-bit valid/ready beats, counting every fully transmitted block.
module aes_block_serializer
  import aes_vp_pkg::*;
#(
  parameter int DATA_W = AES_BLOCK_W,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_fifo_data,
  input  logic              i_fifo_empty,
  output logic              o_fifo_pop,
  output logic [OUT_W-1:0]  o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_blk_cnt
);

  localparam int BEATS = DATA_W / OUT_W;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

  ser_state_e       r_state;
  logic [BC_W-1:0]  r_beat_cnt;
  logic             r_valid;
  logic [CNT_W-1:0] r_blk_cnt;

  logic w_accept;
  logic w_last_beat;
  logic w_load;
  logic w_shift;

  assign w_accept    = r_valid && i_out_ready;
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);
  assign w_load      = i_en && !i_fifo_empty &&
                       ((r_state == IDLE) || ((r_state == SEND) && w_accept && w_last_beat));
  assign w_shift     = w_accept && !w_last_beat;

  // Gate with rst_n so the FIFO is never popped while the block is held in reset.
  assign o_fifo_pop  = w_load && rst_n;

  piso_shift #(
    .DATA_W  (DATA_W),
    .SHIFT_W (OUT_W)
  ) u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (i_fifo_data),
    .o_head  (o_out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_valid    <= 1'b0;
    end else if (w_load) begin
      r_state    <= SEND;
      r_beat_cnt <= '0;
      r_valid    <= 1'b1;
    end else if (w_accept) begin
      if (!w_last_beat) begin
        r_beat_cnt <= r_beat_cnt + BC_W'(1);
      end else begin
        r_valid <= 1'b0;
        r_state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt <= '0;
    end else if (w_accept && w_last_beat) begin
      r_blk_cnt <= r_blk_cnt + CNT_W'(1);
    end
  end

  assign o_out_valid = r_valid;
  assign o_out_last  = r_valid && w_last_beat;
  assign o_busy      = (r_state == SEND);
  assign o_blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_aes_block_serializer.sv
// Scoreboard bench: a queue-based FIFO model feeds the serializer and every pushed
// word enqueues its expected beats, which are checked as the sink accepts them.
module tb_aes_block_serializer;
  import aes_vp_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hFFEEDDCCBBAA99887766554433221100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_en = 1'b0;
  logic [127:0] i_fifo_data = '0;
  logic         i_fifo_empty = 1'b1;
  logic         o_fifo_pop;
  logic [7:0]   o_out_data;
  logic         o_out_valid;
  logic         i_out_ready = 1'b0;
  logic         o_out_last;
  logic         o_busy;
  logic [15:0]  o_blk_cnt;

  logic [127:0] d32_fifo_data = '0;
  logic         d32_fifo_empty = 1'b1;
  logic         d32_pop;
  logic [31:0]  d32_data;
  logic         d32_valid;
  logic         d32_last;
  logic         d32_busy;
  logic [15:0]  d32_blk_cnt;

  logic [127:0] fifo_q[$];
  beat_t        exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int pops = 0;
  int beats_seen = 0;
  int valid_cycles = 0;
  int run_len = 0;
  int max_run = 0;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = '0;
  logic       stall_last = 1'b0;

  always #5 clk = ~clk;

  aes_block_serializer #(.DATA_W(128), .OUT_W(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (i_en),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_pop   (o_fifo_pop),
    .o_out_data   (o_out_data),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_last   (o_out_last),
    .o_busy       (o_busy),
    .o_blk_cnt    (o_blk_cnt)
  );

  aes_block_serializer #(.DATA_W(128), .OUT_W(32), .CNT_W(16)) dut32 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (i_en),
    .i_fifo_data  (d32_fifo_data),
    .i_fifo_empty (d32_fifo_empty),
    .o_fifo_pop   (d32_pop),
    .o_out_data   (d32_data),
    .o_out_valid  (d32_valid),
    .i_out_ready  (i_out_ready),
    .o_out_last   (d32_last),
    .o_busy       (d32_busy),
    .o_blk_cnt    (d32_blk_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic update_fifo();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_word(input logic [127:0] w);
    beat_t b;
    fifo_q.push_back(w);
    for (int k = 0; k < 16; k++) begin
      b.data = w[127-8*k -: 8];
      b.last = (k == 15);
      exp_q.push_back(b);
    end
    update_fifo();
  endtask

  // One clock cycle; called at a falling edge with the next inputs already applied.
  task automatic tick();
    logic       pop;
    logic       acc;
    logic [7:0] d;
    logic       lst;
    beat_t      e;
    #2;
    pop = o_fifo_pop;
    acc = o_out_valid && i_out_ready;
    d   = o_out_data;
    lst = o_out_last;
    if (fifo_q.size() == 0) check("pop_when_empty", pop, 1'b0);
    if (pop && o_out_valid) check("pop_at_last", lst, 1'b1);
    if (stall_pend) begin
      check("stall_valid", o_out_valid, 1'b1);
      check("stall_data", d, stall_data);
      check("stall_last", lst, stall_last);
    end
    stall_pend = o_out_valid && !i_out_ready;
    stall_data = d;
    stall_last = lst;
    if (acc) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", d, e.data);
        check("beat_last", lst, e.last);
      end
      $display("beat data=%02h last=%0b blk_cnt=%0d", d, lst, o_blk_cnt);
      beats_seen++;
    end
    if (o_out_valid) begin
      valid_cycles++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (pop) begin
      pops++;
      $display("pop word=%032h", fifo_q[0]);
    end
    @(posedge clk);
    #1;
    if (pop) void'(fifo_q.pop_front());
    update_fifo();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int p0, b0, v0, guard;

    // Reset state, with a word already waiting and en high
    i_en = 1'b1;
    i_out_ready = 1'b1;
    push_word(BLK_A);
    repeat (2) @(negedge clk);
    #2;
    check("rst_pop", o_fifo_pop, 1'b0);
    check("rst_valid", o_out_valid, 1'b0);
    check("rst_last", o_out_last, 1'b0);
    check("rst_data", o_out_data, 8'h00);
    check("rst_busy", o_busy, 1'b0);
    check("rst_blk_cnt", o_blk_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Case 1: single block, sink always ready
    p0 = pops; b0 = beats_seen; v0 = valid_cycles;
    tick();
    check("c1_first_pop", pops - p0, 1);
    check("c1_latency_valid", o_out_valid, 1'b1);
    ticks(20);
    check("c1_pops", pops - p0, 1);
    check("c1_beats", beats_seen - b0, 16);
    check("c1_valid_cycles", valid_cycles - v0, 16);
    check("c1_blk_cnt", o_blk_cnt, 16'd1);
    check("c1_idle_valid", o_out_valid, 1'b0);
    check("c1_idle_busy", o_busy, 1'b0);

    // Case 2: ready pattern 1,0,0 repeating
    p0 = pops; b0 = beats_seen;
    push_word(BLK_A);
    for (int k = 0; k < 60; k++) begin
      i_out_ready = (k % 3 == 0);
      tick();
    end
    i_out_ready = 1'b1;
    ticks(4);
    check("c2_pops", pops - p0, 1);
    check("c2_beats", beats_seen - b0, 16);
    check("c2_blk_cnt", o_blk_cnt, 16'd2);

    // Case 3: two queued words stream back to back
    p0 = pops; b0 = beats_seen; v0 = valid_cycles; max_run = 0;
    push_word(BLK_A);
    push_word(BLK_B);
    ticks(40);
    check("c3_pops", pops - p0, 2);
    check("c3_beats", beats_seen - b0, 32);
    check("c3_valid_cycles", valid_cycles - v0, 32);
    check("c3_continuous", max_run, 32);
    check("c3_blk_cnt", o_blk_cnt, 16'd4);

    // Case 4: enabled but nothing to send
    p0 = pops; v0 = valid_cycles;
    ticks(20);
    check("c4_pops", pops - p0, 0);
    check("c4_valid", valid_cycles - v0, 0);
    check("c4_busy", o_busy, 1'b0);

    // Case 5: en dropped mid-block with a second word queued
    p0 = pops; b0 = beats_seen;
    push_word(BLK_A);
    push_word(BLK_B);
    guard = 0;
    while ((beats_seen - b0 < 5) && (guard < 50)) begin
      tick();
      guard++;
    end
    check("c5_reach_beat5", guard < 50, 1'b1);
    i_en = 1'b0;
    ticks(30);
    check("c5_pops_held", pops - p0, 1);
    check("c5_beats_blk1", beats_seen - b0, 16);
    check("c5_blk_cnt", o_blk_cnt, 16'd5);
    check("c5_word_kept", fifo_q.size(), 1);
    check("c5_idle_valid", o_out_valid, 1'b0);
    i_en = 1'b1;
    tick();
    check("c5_restart_pop", pops - p0, 2);
    check("c5_restart_valid", o_out_valid, 1'b1);
    ticks(20);
    check("c5_blk_cnt_2", o_blk_cnt, 16'd6);

    // Case 6: asynchronous reset at beat 8, then next queued word from its first byte
    b0 = beats_seen;
    push_word(BLK_A);
    push_word(BLK_B);
    guard = 0;
    while ((beats_seen - b0 < 8) && (guard < 50)) begin
      tick();
      guard++;
    end
    check("c6_reach_beat8", guard < 50, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("c6_rst_valid", o_out_valid, 1'b0);
    check("c6_rst_last", o_out_last, 1'b0);
    check("c6_rst_busy", o_busy, 1'b0);
    check("c6_rst_blk_cnt", o_blk_cnt, 16'd0);
    check("c6_rst_pop", o_fifo_pop, 1'b0);
    stall_pend = 1'b0;
    run_len = 0;
    while (exp_q.size() > 16 * fifo_q.size()) void'(exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b0 = beats_seen;
    ticks(20);
    check("c6_beats_after", beats_seen - b0, 16);
    check("c6_blk_cnt", o_blk_cnt, 16'd1);
    check("c6_exp_drained", exp_q.size(), 0);

    // OUT_W=32 instance: single block of four words
    i_en = 1'b1;
    i_out_ready = 1'b1;
    d32_fifo_data = BLK_A;
    d32_fifo_empty = 1'b0;
    #2;
    check("w32_pop", d32_pop, 1'b1);
    @(posedge clk);
    #1;
    d32_fifo_empty = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [127:0] ref_word;
      @(negedge clk);
      ref_word = BLK_A;
      check("w32_valid", d32_valid, 1'b1);
      check("w32_data", d32_data, ref_word[127-32*k -: 32]);
      check("w32_last", d32_last, (k == 3));
      $display("beat32 data=%08h last=%0b", d32_data, d32_last);
    end
    @(negedge clk);
    check("w32_idle_valid", d32_valid, 1'b0);
    check("w32_blk_cnt", d32_blk_cnt, 16'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
